// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs, FSM states, ALU ops.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_t;

    function automatic alu_op_t decode_alu(input logic [5:0] opcode, input logic [5:0] funct);
        alu_op_t op;
        op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_SUB:   op = ALU_SUB;
                    F_AND:   op = ALU_AND;
                    F_OR:    op = ALU_OR;
                    F_SLT:   op = ALU_SLT;
                    F_SLL:   op = ALU_SLL;
                    default: op = ALU_ADD;
                endcase
            end
            OP_ORI:  op = ALU_OR;
            OP_BEQ:  op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port with a req/ready handshake.
interface mips_multicycle_core_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_alu.sv
// Combinational ALU for the multi-cycle core; wrapping arithmetic, signed slt.
module mc_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    input  logic [4:0]  shamt,
    output logic [31:0] y,
    output logic        zero
);
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLL: y = b << shamt;
            default: y = '0;
        endcase
        zero = (y == '0);
    end
endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core sharing one memory port for fetch and load/store.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned HALT_ON_ILLEGAL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_core_if.master mem,
    output logic [ADDR_W-1:0]      pc_out,
    output logic                   retire,
    output logic                   halted
);
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam logic [RW-1:0] LINK_IDX = RW'(31);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_cur, br_target;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       regs [NUM_REGS];

    logic [5:0]        opcode, funct;
    logic [4:0]        rs_f, rt_f, rd_f, shamt;
    logic [RW-1:0]     rs_idx, rt_idx, rd_idx, wb_idx;
    logic [31:0]       imm_sext, imm_zext, alu_b, alu_y, br_off, jump32, pc_wide;
    logic              alu_zero, legal, complete;
    logic              is_rtype, is_jump, is_jal, is_beq, is_lw, is_sw;
    alu_op_t           alu_op;

    assign opcode   = ir[31:26];
    assign rs_f     = ir[25:21];
    assign rt_f     = ir[20:16];
    assign rd_f     = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign rs_idx   = rs_f[RW-1:0];
    assign rt_idx   = rt_f[RW-1:0];
    assign rd_idx   = rd_f[RW-1:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign imm_zext = {16'd0, ir[15:0]};
    assign br_off   = {imm_sext[29:0], 2'b00};
    assign pc_wide  = 32'(pc);
    assign jump32   = {pc_wide[31:28], ir[25:0], 2'b00};

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jump  = (opcode == OP_J) || is_jal;
    assign is_beq   = (opcode == OP_BEQ);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign wb_idx   = is_rtype ? rd_idx : rt_idx;
    assign alu_op   = decode_alu(opcode, funct);
    assign alu_b    = (is_rtype || is_beq) ? b : ((opcode == OP_ORI) ? imm_zext : imm_sext);

    always_comb begin
        case (opcode)
            OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL};
            OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    mc_alu u_alu (
        .a     (a),
        .b     (alu_b),
        .op    (alu_op),
        .shamt (shamt),
        .y     (alu_y),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  if (mem.mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                if (!legal)       state_next = (HALT_ON_ILLEGAL != 0) ? ST_HALT : ST_FETCH;
                else if (is_jump) state_next = ST_FETCH;
                else              state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_beq)              state_next = ST_FETCH;
                else if (is_lw || is_sw) state_next = ST_MEM;
                else                     state_next = ST_WB;
            end
            ST_MEM:    if (mem.mem_ready) state_next = is_sw ? ST_FETCH : ST_WB;
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    // FETCH is also the reset state, so the request is masked while rst is held.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = pc;
        mem.mem_wdata = b;
        complete      = 1'b0;
        case (state)
            ST_FETCH:  mem.mem_req = !rst;
            ST_DECODE: complete = is_jump || (!legal && (HALT_ON_ILLEGAL == 0));
            ST_EXEC:   complete = is_beq;
            ST_MEM: begin
                mem.mem_req  = !rst;
                mem.mem_we   = is_sw && !rst;
                mem.mem_addr = {alu_out[ADDR_W-1:2], 2'b00};
                complete     = is_sw && mem.mem_ready;
            end
            ST_WB:     complete = 1'b1;
            default:   ;
        endcase
    end

    assign halted = (state == ST_HALT);
    assign pc_out = (state == ST_FETCH) ? pc : pc_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC[ADDR_W-1:0];
            pc_cur    <= RESET_PC[ADDR_W-1:0];
            br_target <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            retire    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            retire <= complete;
            case (state)
                ST_FETCH: begin
                    if (mem.mem_ready) begin
                        ir     <= mem.mem_rdata;
                        pc_cur <= pc;
                        pc     <= pc + ADDR_W'(4);
                    end
                end
                ST_DECODE: begin
                    a         <= regs[rs_idx];
                    b         <= regs[rt_idx];
                    br_target <= pc + br_off[ADDR_W-1:0];
                    if (is_jump) pc <= jump32[ADDR_W-1:0];
                    if (is_jal)  regs[LINK_IDX] <= pc_wide;
                end
                ST_EXEC: begin
                    alu_out <= alu_y;
                    if (is_beq && alu_zero) pc <= br_target;
                end
                ST_MEM: if (mem.mem_ready && is_lw) mdr <= mem.mem_rdata;
                ST_WB:  if (wb_idx != '0) regs[wb_idx] <= is_lw ? mdr : alu_out;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a wait-state-configurable memory model.
module tb_mips_multicycle_core;
    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_out;
    logic        retire, halted;

    int unsigned checks = 0;
    int unsigned failures = 0;

    int unsigned lat = 0;
    int unsigned wcnt = 0;
    logic        clr = 1'b0;
    logic [31:0] fill = '0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] mem [256];

    mips_multicycle_core_if #(.ADDR_W(32)) bus ();

    mips_multicycle_core #(
        .ADDR_W(32), .RESET_PC(32'h0), .NUM_REGS(32), .HALT_ON_ILLEGAL(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem    (bus),
        .pc_out (pc_out),
        .retire (retire),
        .halted (halted)
    );

    always #5 clk = ~clk;

    assign bus.mem_ready = bus.mem_req && (wcnt >= lat);
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill;
        end else if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end else if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
        else                               wcnt <= 0;
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic clear(input logic [31:0] value);
        fill = value;
        clr  = 1'b1;
        tick();
        clr  = 1'b0;
    endtask

    task automatic poke(input int unsigned idx, input logic [31:0] data);
        ld_idx  = 8'(idx);
        ld_data = data;
        ld_en   = 1'b1;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic start(input int unsigned l);
        lat = l;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] addr);
        check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_addr"}, bus.mem_addr, addr);
    endtask

    task automatic wait_halt(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        // reset state
        ticks(2);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", pc_out, 32'h0);

        // A: arithmetic, retire timing, store/load round trip, illegal opcode
        clear('0);
        poke(0, enc_i(OP_ADDI, 0, 1, 16'd5));
        poke(1, enc_i(OP_ADDI, 0, 2, 16'hFFFD));
        poke(2, enc_r(1, 2, 3, 0, F_ADD));
        poke(3, enc_j(OP_J, 26'h8));
        poke(8, enc_i(OP_SW, 0, 3, 16'h10));
        poke(9, enc_i(OP_LW, 0, 5, 16'h10));
        poke(10, enc_i(OP_SW, 0, 5, 16'h14));
        poke(11, ILLEGAL);
        start(0);
        ticks(3);  check("a_retire_e3", 32'(retire), 32'd0);
        tick();    check("a_retire_e4", 32'(retire), 32'd1);
        tick();    check("a_retire_e5", 32'(retire), 32'd0);
        ticks(3);  check("a_retire_e8", 32'(retire), 32'd1);
        ticks(4);  check("a_retire_e12", 32'(retire), 32'd1);
        ticks(2);  check_fetch("a_jtarget", 32'h20);
        ticks(3);
        check("a_sw_we", 32'(bus.mem_we), 32'd1);
        check("a_sw_addr", bus.mem_addr, 32'h10);
        check("a_sw_wdata", bus.mem_wdata, 32'd2);
        ticks(9);
        check("a_sw2_we", 32'(bus.mem_we), 32'd1);
        check("a_sw2_addr", bus.mem_addr, 32'h14);
        check("a_lw_r5", bus.mem_wdata, 32'd2);
        ticks(3);
        check("a_halted", 32'(halted), 32'd1);
        check("a_halt_req", 32'(bus.mem_req), 32'd0);
        ticks(20);
        check("a_halt_stay", 32'(halted), 32'd1);
        check("a_halt_req_stay", 32'(bus.mem_req), 32'd0);
        check("a_halt_retire", 32'(retire), 32'd0);
        check("a_mem10", mem[4], 32'd2);

        // B: branches, jumps, jal link, r0 writes
        rst = 1'b1;
        clear('0);
        poke(0, enc_i(OP_ADDI, 0, 1, 16'd5));
        poke(1, enc_i(OP_ADDI, 0, 2, 16'hFFFD));
        poke(2, enc_j(OP_J, 26'h8));
        poke(8, enc_i(OP_BEQ, 1, 1, 16'd2));
        poke(11, enc_i(OP_BEQ, 1, 2, 16'd5));
        poke(12, enc_j(OP_J, 26'h4));
        poke(4, enc_j(OP_JAL, 26'h40));
        poke(64, enc_i(OP_ADDI, 0, 0, 16'd7));
        poke(65, enc_i(OP_SW, 0, 0, 16'h40));
        poke(66, enc_i(OP_SW, 0, 31, 16'h44));
        poke(67, ILLEGAL);
        start(0);
        ticks(10); check_fetch("b_j", 32'h20);
        check("b_pc_out", pc_out, 32'h20);
        ticks(3);  check_fetch("b_beq_taken", 32'h2C);
        check("b_beq_retire", 32'(retire), 32'd1);
        ticks(3);  check_fetch("b_beq_not_taken", 32'h30);
        ticks(2);  check_fetch("b_j_back", 32'h10);
        ticks(2);  check_fetch("b_jal", 32'h100);
        check("b_jal_retire", 32'(retire), 32'd1);
        ticks(7);
        check("b_r0_addr", bus.mem_addr, 32'h40);
        check("b_r0_value", bus.mem_wdata, 32'd0);
        ticks(4);
        check("b_r31_addr", bus.mem_addr, 32'h44);
        check("b_r31_value", bus.mem_wdata, 32'h14);
        ticks(3);
        check("b_halted", 32'(halted), 32'd1);

        // C: three wait states per access
        rst = 1'b1;
        clear('0);
        poke(0, enc_i(OP_LW, 0, 4, 16'h8));
        poke(1, enc_i(OP_SW, 0, 4, 16'h30));
        poke(2, 32'hDEAD_BEEF);
        start(3);
        ticks(3);  check_fetch("c_fetch_wait", 32'h0);
        check("c_fetch_wait_retire", 32'(retire), 32'd0);
        ticks(3);  check_fetch("c_mem_e6", 32'h8);
        for (int k = 7; k <= 9; k++) begin
            tick();
            check($sformatf("c_mem_hold_e%0d", k), bus.mem_addr, 32'h8);
            check($sformatf("c_mem_req_e%0d", k), 32'(bus.mem_req), 32'd1);
        end
        tick();    check("c_retire_e10", 32'(retire), 32'd0);
        tick();    check("c_retire_e11", 32'(retire), 32'd1);
        wait_halt("c_halt", 40);
        check("c_r4", mem[12], 32'hDEAD_BEEF);

        // D: reset while a data access is pending
        rst = 1'b1;
        clear('0);
        poke(0, enc_i(OP_LW, 0, 4, 16'h8));
        poke(1, enc_i(OP_SW, 0, 4, 16'h30));
        poke(2, 32'hCAFE_F00D);
        start(0);
        ticks(3);  check_fetch("d_mem", 32'h8);
        lat = 50;
        #2 rst = 1'b1;
        #1;
        check("d_async_req", 32'(bus.mem_req), 32'd0);
        check("d_async_we", 32'(bus.mem_we), 32'd0);
        lat = 0;
        ticks(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_fetch("d_refetch", 32'h0);
        check("d_pc_out", pc_out, 32'h0);
        ticks(5);  check("d_lw_retire", 32'(retire), 32'd1);
        wait_halt("d_halt", 40);
        check("d_r4", mem[12], 32'hCAFE_F00D);

        // E: ALU operations, immediate extension, negative load offset, illegal funct
        rst = 1'b1;
        clear(32'hA5A5_A5A5);
        poke(0, enc_i(OP_ADDI, 0, 1, 16'd5));
        poke(1, enc_i(OP_ADDI, 0, 2, 16'hFFFD));
        poke(2, enc_i(OP_ADDI, 0, 8, 16'd255));
        poke(3, enc_i(OP_ORI, 0, 9, 16'hF0F0));
        poke(4, enc_r(1, 2, 6, 0, F_SUB));
        poke(5, enc_r(9, 8, 7, 0, F_AND));
        poke(6, enc_r(9, 8, 10, 0, F_OR));
        poke(7, enc_r(2, 1, 11, 0, F_SLT));
        poke(8, enc_r(1, 2, 12, 0, F_SLT));
        poke(9, enc_r(0, 1, 13, 4, F_SLL));
        poke(10, enc_r(2, 2, 14, 0, F_ADD));
        poke(11, enc_i(OP_SW, 0, 6, 16'h200));
        poke(12, enc_i(OP_SW, 0, 7, 16'h204));
        poke(13, enc_i(OP_SW, 0, 9, 16'h208));
        poke(14, enc_i(OP_SW, 0, 10, 16'h20C));
        poke(15, enc_i(OP_SW, 0, 11, 16'h210));
        poke(16, enc_i(OP_SW, 0, 12, 16'h214));
        poke(17, enc_i(OP_SW, 0, 13, 16'h218));
        poke(18, enc_i(OP_SW, 0, 14, 16'h21C));
        poke(19, enc_i(OP_LW, 0, 15, 16'hFFFC));
        poke(20, enc_i(OP_SW, 0, 15, 16'h220));
        poke(21, enc_r(0, 0, 0, 0, 6'h3F));
        poke(255, 32'h1234_5678);
        start(0);
        wait_halt("e_halt", 300);
        check("e_sub", mem[128], 32'd8);
        check("e_and", mem[129], 32'h0000_00F0);
        check("e_ori_zext", mem[130], 32'h0000_F0F0);
        check("e_or", mem[131], 32'h0000_F0FF);
        check("e_slt_true", mem[132], 32'd1);
        check("e_slt_signed", mem[133], 32'd0);
        check("e_sll", mem[134], 32'h0000_0050);
        check("e_add_wrap", mem[135], 32'hFFFF_FFFA);
        check("e_lw_neg_off", mem[136], 32'h1234_5678);
        check("e_halt_req", 32'(bus.mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
